// File: rtl/alu_mul_seq_if.sv
// Purpose: request/result and shared-ALU signal bundle for alu_mul_seq.
// Latency: none, wires only; all timing belongs to the multiplier.
// Backpressure: none here; the multiplier drops START while BUSY is high.
//
// Signal summary (directions as seen by the multiplier, i.e. the slave modport):
//   i_start, i_opa[15:0], i_opb[15:0]     request and operands
//   o_busy, o_done, o_result[15:0], o_ovf  status and held result
//   o_alu_s[3:0], o_alu_a, o_alu_b         command to the shared ALU
//   i_alu_y[15:0], i_alu_flag[3:0]         same-cycle ALU response {S,Z,C,V}
interface alu_mul_seq_if;
  logic        i_start;
  logic [15:0] i_opa;
  logic [15:0] i_opb;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_result;
  logic        o_ovf;
  logic [3:0]  o_alu_s;
  logic [15:0] o_alu_a;
  logic [15:0] o_alu_b;
  logic [15:0] i_alu_y;
  logic [3:0]  i_alu_flag;

  modport slave (
    input  i_start, i_opa, i_opb, i_alu_y, i_alu_flag,
    output o_busy, o_done, o_result, o_ovf, o_alu_s, o_alu_a, o_alu_b
  );

  modport master (
    output i_start, i_opa, i_opb, i_alu_y, i_alu_flag,
    input  o_busy, o_done, o_result, o_ovf, o_alu_s, o_alu_a, o_alu_b
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Purpose: sequential shift-and-add 16x16 unsigned multiplier driving an external shared ALU.
// Latency: DONE in the cycle after op edge N, N = BITS + popcount(OPB masked to BITS).
// Backpressure: START accepted only in IDLE/DONE; START while BUSY is silently dropped.
//
// Ports: i_clk (rising edge), i_rst_n (async, active-low), bus (alu_mul_seq_if.slave).
// Parameter BITS (1..16): number of multiplier LSBs iterated; higher OPB bits ignored.
// Optional feature macro MULSEQ_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier is zero, checked at every iteration entry including right after accept.
module alu_mul_seq #(
  parameter int BITS = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_mul_seq_if.slave bus
);

  localparam logic [15:0] MASK   = 16'((33'd1 << BITS) - 33'd1);
  localparam logic [4:0]  LAST   = 5'(BITS - 1);
  localparam logic [3:0]  OP_ADD = 4'b0000;
  localparam logic [3:0]  OP_SLL = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHL, S_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_ovf;

  logic        w_enter;
  logic        w_carry;
  logic        w_ovf_shl;
  logic        w_last;
  logic [15:0] w_mplier_sh;
  logic [15:0] w_ent_acc;
  logic [15:0] w_ent_mcand;
  logic [15:0] w_ent_mplier;
  logic        w_ent_ovf;
  state_t      w_nxt_state;
  logic [3:0]  w_nxt_alu_s;
  logic [15:0] w_nxt_alu_a;
  logic [15:0] w_nxt_alu_b;
  logic        w_unused_flags;

  // An iteration is entered either from an accept or from the end of a shift.
  assign w_enter = (((r_state == S_IDLE) || (r_state == S_DONE)) && bus.i_start)
                   || (r_state == S_SHL);
  assign w_carry        = bus.i_alu_flag[1];
  assign w_mplier_sh    = r_mplier >> 1;
  // A bit shifted off the multiplicand only matters if multiplier bits remain to use it.
  assign w_ovf_shl      = r_ovf | (w_carry && (w_mplier_sh != 16'h0000));
  assign w_last         = (r_cnt == LAST);
  assign w_unused_flags = ^{bus.i_alu_flag[3:2], bus.i_alu_flag[0]};

  // Next-iteration decision. ALU command is registered, so operands for the next
  // op cycle are chosen here from the values the registers will hold after this edge.
  always_comb begin
    w_ent_acc    = 16'h0000;
    w_ent_mcand  = bus.i_opa;
    w_ent_mplier = bus.i_opb & MASK;
    w_ent_ovf    = 1'b0;
    if (r_state == S_SHL) begin
      w_ent_acc    = r_acc;
      w_ent_mcand  = bus.i_alu_y;
      w_ent_mplier = w_mplier_sh;
      w_ent_ovf    = w_ovf_shl;
    end

    w_nxt_state = S_SHL;
    w_nxt_alu_s = OP_SLL;
    w_nxt_alu_a = w_ent_mcand;
    w_nxt_alu_b = 16'h0001;
    if (w_ent_mplier[0]) begin
      w_nxt_state = S_ADD;
      w_nxt_alu_s = OP_ADD;
      w_nxt_alu_a = w_ent_acc;
      w_nxt_alu_b = w_ent_mcand;
    end

`ifdef MULSEQ_EARLY_EXIT_EN
    if (w_ent_mplier == 16'h0000) begin
      w_nxt_state = S_DONE;
      w_nxt_alu_s = OP_ADD;
      w_nxt_alu_a = 16'h0000;
      w_nxt_alu_b = 16'h0000;
    end
`endif

    if ((r_state == S_SHL) && w_last) begin
      w_nxt_state = S_DONE;
      w_nxt_alu_s = OP_ADD;
      w_nxt_alu_a = 16'h0000;
      w_nxt_alu_b = 16'h0000;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= 16'h0000;
      r_mcand      <= 16'h0000;
      r_mplier     <= 16'h0000;
      r_cnt        <= 5'd0;
      r_ovf        <= 1'b0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
      bus.o_result <= 16'h0000;
      bus.o_ovf    <= 1'b0;
      bus.o_alu_s  <= OP_ADD;
      bus.o_alu_a  <= 16'h0000;
      bus.o_alu_b  <= 16'h0000;
    end else begin
      bus.o_done <= 1'b0;
      case (r_state)
        S_ADD: begin
          r_acc       <= bus.i_alu_y;
          r_ovf       <= r_ovf | w_carry;
          r_state     <= S_SHL;
          bus.o_alu_s <= OP_SLL;
          bus.o_alu_a <= r_mcand;
          bus.o_alu_b <= 16'h0001;
        end
        S_SHL: begin
          r_mcand  <= bus.i_alu_y;
          r_mplier <= w_mplier_sh;
          r_ovf    <= w_ovf_shl;
          r_cnt    <= r_cnt + 5'd1;
        end
        default: begin
          // IDLE and DONE behave the same: wait for a request.
          if (bus.i_start) begin
            r_acc    <= 16'h0000;
            r_mcand  <= bus.i_opa;
            r_mplier <= bus.i_opb & MASK;
            r_cnt    <= 5'd0;
            r_ovf    <= 1'b0;
          end else begin
            r_state     <= S_IDLE;
            bus.o_busy  <= 1'b0;
            bus.o_alu_s <= OP_ADD;
            bus.o_alu_a <= 16'h0000;
            bus.o_alu_b <= 16'h0000;
          end
        end
      endcase

      if (w_enter) begin
        r_state     <= w_nxt_state;
        bus.o_busy  <= (w_nxt_state == S_ADD) || (w_nxt_state == S_SHL);
        bus.o_alu_s <= w_nxt_alu_s;
        bus.o_alu_a <= w_nxt_alu_a;
        bus.o_alu_b <= w_nxt_alu_b;
        if (w_nxt_state == S_DONE) begin
          bus.o_done   <= 1'b1;
          bus.o_result <= w_ent_acc;
          bus.o_ovf    <= w_ent_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Purpose: self-checking bench for alu_mul_seq with an in-bench ALU and a
// transaction-level reference (product arithmetic + op-cycle counts).
// Stimulus: directed corner cases followed by randomized operands and stray STARTs.
module tb_alu_mul_seq;
  localparam int          BITS = 16;
  localparam logic [15:0] MASK = 16'((33'd1 << BITS) - 33'd1);
`ifdef MULSEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst_n;

  alu_mul_seq_if bus();

  alu_mul_seq #(.BITS(BITS)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;
  int edge_cnt = 0;
  int acc_e    = 0;

  always @(posedge i_clk) edge_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  // Shift cycles: all BITS normally; only up to the top set bit with early exit.
  function automatic int exp_shifts(input logic [15:0] m);
    int h = 0;
    for (int i = 0; i < 16; i++) if (m[i]) h = i + 1;
    return EE ? h : BITS;
  endfunction

  function automatic int exp_lat(input logic [15:0] b);
    return popc(b & MASK) + exp_shifts(b & MASK);
  endfunction

  // ---------------- shared ALU model (combinational) ----------------
  logic [16:0] alu_wide;
  logic [15:0] alu_y_m;
  logic [3:0]  alu_flag_m;
  logic [15:0] junk_y = 16'h0;
  logic [3:0]  junk_f = 4'h0;

  always_comb begin
    alu_wide = 17'h0;
    case (bus.o_alu_s)
      4'b0000: alu_wide = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
      4'b1000: alu_wide = {1'b0, bus.o_alu_a} << bus.o_alu_b[3:0];
      default: alu_wide = 17'h0;
    endcase
    alu_y_m    = alu_wide[15:0];
    alu_flag_m = {alu_y_m[15], (alu_y_m == 16'h0), alu_wide[16],
                  (bus.o_alu_s == 4'b0000) && (bus.o_alu_a[15] == bus.o_alu_b[15])
                  && (alu_y_m[15] != bus.o_alu_a[15])};
    // Outside op cycles the ALU output belongs to someone else: feed garbage.
    bus.i_alu_y    = bus.o_busy ? alu_y_m    : junk_y;
    bus.i_alu_flag = bus.o_busy ? alu_flag_m : junk_f;
  end

  always @(negedge i_clk) begin
    junk_y = 16'($urandom);
    junk_f = 4'($urandom);
  end

  // ---------------- transaction-level reference ----------------
  logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;
  logic [15:0] m_res = 16'h0, p_res = 16'h0;
  logic [31:0] prod;
  int          m_rem = 0, p_adds = 0, p_shifts = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = 16'h0; m_ovf = 1'b0; m_rem = 0;
    end else if (m_busy) begin
      m_done = 1'b0;
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_res = p_res; m_ovf = p_ovf;
      end
    end else begin
      m_done = 1'b0;
      if (bus.i_start) begin
        prod     = {16'h0, bus.i_opa} * {16'h0, bus.i_opb & MASK};
        p_res    = prod[15:0];
        p_ovf    = (prod > 32'h0000FFFF);
        p_adds   = popc(bus.i_opb & MASK);
        p_shifts = exp_shifts(bus.i_opb & MASK);
        m_rem    = p_adds + p_shifts;
        if (m_rem == 0) begin
          m_done = 1'b1; m_res = p_res; m_ovf = p_ovf;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int adds_seen = 0, shifts_seen = 0;

  always @(negedge i_clk) begin
    chk("busy",   32'(bus.o_busy),   32'(m_busy));
    chk("done",   32'(bus.o_done),   32'(m_done));
    chk("result", 32'(bus.o_result), 32'(m_res));
    chk("ovf",    32'(bus.o_ovf),    32'(m_ovf));
    if (!m_busy) begin
      chk("alu_s_quiet", 32'(bus.o_alu_s), 32'h0);
      chk("alu_a_quiet", 32'(bus.o_alu_a), 32'h0);
      chk("alu_b_quiet", 32'(bus.o_alu_b), 32'h0);
    end else begin
      chk("alu_s_legal", 32'((bus.o_alu_s == 4'b0000) || (bus.o_alu_s == 4'b1000)), 32'h1);
      if (bus.o_alu_s == 4'b0000) adds_seen++;
      else shifts_seen++;
    end
    if (m_done) begin
      chk("add_cycles",   32'(adds_seen),   32'(p_adds));
      chk("shift_cycles", 32'(shifts_seen), 32'(p_shifts));
    end
    if (!m_busy) begin
      adds_seen = 0;
      shifts_seen = 0;
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    bus.i_opa   = a;
    bus.i_opb   = b;
    bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    acc_e = edge_cnt;
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [15:0] res, input logic ovf);
    int k;
    k = 0;
    while (!bus.o_done && k < 200) begin
      @(negedge i_clk);
      k++;
    end
    if (!bus.o_done) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got no DONE within 200 cycles, expected DONE", nm);
    end else begin
      chk({nm, "_latency"}, 32'(edge_cnt - acc_e), 32'(lat));
      chk({nm, "_result"},  32'(bus.o_result), 32'(res));
      chk({nm, "_ovf"},     32'(bus.o_ovf), 32'(ovf));
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 255));
      2:       return 16'h0000;
      3:       return 16'(16'h0001 << $urandom_range(0, 15));
      default: return 16'hFFFF;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected $finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rp;
    logic [15:0] a, b;
    int          dones, r, gap;

    bus.i_start = 1'b0;
    bus.i_opa   = 16'h0;
    bus.i_opb   = 16'h0;
    i_rst_n     = 1'b1;
    #1 i_rst_n  = 1'b0;
    @(negedge i_clk);
    #1;
    chk("rst_busy",   32'(bus.o_busy),   32'h0);
    chk("rst_done",   32'(bus.o_done),   32'h0);
    chk("rst_result", 32'(bus.o_result), 32'h0);
    chk("rst_ovf",    32'(bus.o_ovf),    32'h0);
    chk("rst_alu_s",  32'(bus.o_alu_s),  32'h0);
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);

    start_op(16'd3, 16'd5);
    wait_done("mul_3x5", EE ? 5 : 18, 16'h000F, 1'b0);
    @(negedge i_clk);
    start_op(16'h0100, 16'h0100);
    wait_done("ovf_256sq", EE ? 10 : 17, 16'h0000, 1'b1);
    @(negedge i_clk);
    start_op(16'hFFFF, 16'h0001);
    wait_done("max_x1", EE ? 2 : 17, 16'hFFFF, 1'b0);
    @(negedge i_clk);
    start_op(16'h1234, 16'h0000);
    wait_done("opb_zero", EE ? 0 : 16, 16'h0000, 1'b0);
    @(negedge i_clk);

    // Second START while busy must be dropped.
    start_op(16'h00AB, 16'h0031);
    repeat (2) @(negedge i_clk);
    bus.i_opa = 16'h5555; bus.i_opb = 16'h5555; bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    wait_done("busy_start", EE ? 9 : 19, 16'h20BB, 1'b0);
    dones = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (bus.o_done) dones++;
    end
    chk("busy_start_extra_done", 32'(dones), 32'h0);

    // Back-to-back: new START presented in the DONE cycle.
    start_op(16'd3, 16'd5);
    wait_done("b2b_first", EE ? 5 : 18, 16'h000F, 1'b0);
    start_op(16'd7, 16'd6);
    wait_done("b2b_second", EE ? 5 : 18, 16'h002A, 1'b0);
    @(negedge i_clk);

    // Reset in the middle of an operation.
    start_op(16'h1234, 16'h00FF);
    while (edge_cnt - acc_e < 7) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_busy",   32'(bus.o_busy),   32'h0);
    chk("midrst_result", 32'(bus.o_result), 32'h0);
    chk("midrst_done",   32'(bus.o_done),   32'h0);
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (bus.o_done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'h0);
    start_op(16'd2, 16'd2);
    wait_done("after_rst", EE ? 3 : 17, 16'h0004, 1'b0);
    @(negedge i_clk);

    // Randomized operations, stray STARTs while busy, variable gaps.
    for (int t = 0; t < 40; t++) begin
      a = pick_operand();
      b = pick_operand();
      start_op(a, b);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 5);
        for (int i = 0; i < r && m_busy; i++) @(negedge i_clk);
        if (m_busy) begin
          bus.i_opa   = 16'($urandom);
          bus.i_opb   = 16'($urandom);
          bus.i_start = 1'b1;
          @(negedge i_clk);
          bus.i_start = 1'b0;
        end
      end
      rp = {16'h0, a} * {16'h0, b & MASK};
      wait_done("rand", exp_lat(b), rp[15:0], rp > 32'h0000FFFF);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge i_clk);
    end

    repeat (3) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter: BITS, 16, number of multiplier LSBs iterated (1..16); multiplier bits at and above BITS ignored.
REQ-002 CLK  input  1  single clock; all state on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  request; samples OPA/OPB when accepted.
REQ-005 OPA  input  16  multiplicand, unsigned.
REQ-006 OPB  input  16  multiplier, unsigned.
REQ-007 BUSY  output  1  high while an operation is sequencing.
REQ-008 DONE  output  1  one-cycle pulse; RESULT/OVF valid.
REQ-009 RESULT  output  16  low 16 bits of OPA*OPB, held until next DONE.
REQ-010 OVF  output  1  high when the true product exceeds 0xFFFF; held with RESULT.
REQ-011 ALU_S  output  4  opcode to the shared 16-bit ALU (ADD=0000, SLL=1000).
REQ-012 ALU_A  output  16  ALU operand A.
REQ-013 ALU_B  output  16  ALU operand B.
REQ-014 ALU_Y  input  16  ALU result, combinational in the same cycle.
REQ-015 ALU_FLAG  input  4  ALU flags {S,Z,C,V}; only C (bit 1) is used.

Function
REQ-016 States SHALL be IDLE, ADD, SHL and DONE; BUSY=1 in ADD/SHL, 0 in IDLE/DONE.
REQ-017 START SHALL be accepted only in IDLE or DONE; START while BUSY=1 SHALL be ignored.
REQ-018 Accept SHALL load MCAND=OPA, MPLIER=OPB masked to BITS bits, ACC=0, CNT=0, sticky OVF_R=0.
REQ-019 Iteration entry: MPLIER[0]=1 SHALL go to ADD; otherwise SHL.
REQ-020 ADD cycle SHALL drive ALU_S=0000, ALU_A=ACC, ALU_B=MCAND, load ACC<=ALU_Y and set OVF_R|=C, then go to SHL.
REQ-021 SHL cycle SHALL drive ALU_S=1000, ALU_A=MCAND, ALU_B=0x0001 and perform these updates:
- MCAND<=ALU_Y.
- MPLIER<=MPLIER>>1.
- OVF_R|=C AND (MPLIER>>1 != 0).
- CNT<=CNT+1.
REQ-022 After an SHL with CNT==BITS-1, the next state SHALL be DONE; otherwise the next iteration SHALL be entered.
REQ-023 In IDLE and DONE, outputs SHALL be ALU_S=0000 and ALU_A=ALU_B=0x0000.
REQ-024 On entry to DONE, RESULT<=ACC and OVF<=OVF_R.
REQ-025 DONE SHALL last one cycle and go to IDLE, or start directly if START is accepted.
REQ-026 Latency: with edge 0 the accepting edge and N the op-cycle count (adds + shifts), DONE SHALL be high in the cycle after edge N.
REQ-027 Without early exit, N SHALL be BITS + popcount(masked OPB).
REQ-028 ALU_Y/ALU_FLAG SHALL be ignored outside ADD/SHL.

Reset
REQ-029 RST_N low SHALL immediately force IDLE and clear all of the following:
- outputs BUSY, DONE, RESULT, OVF, ALU_S, ALU_A, ALU_B;
- internal ACC, MCAND, MPLIER, CNT, OVF_R.
REQ-030 Reset mid-operation SHALL abort the operation with no DONE pulse; START SHALL be accepted from the first edge after RST_N rises.

Configuration
REQ-031 With MULSEQ_EARLY_EXIT_EN defined, at each iteration entry (including immediately after accept) MPLIER==0 SHALL go to DONE instead of ADD/SHL.
REQ-032 With MULSEQ_EARLY_EXIT_EN defined, OPB=0 SHALL give N=0, i.e. DONE in the cycle after edge 0.
REQ-033 Without MULSEQ_EARLY_EXIT_EN, exactly BITS iterations SHALL always run.

Verification (BITS=16)
REQ-034 OPA=3, OPB=5, no macro -> DONE after edge 18, RESULT=0x000F, OVF=0.
REQ-035 OPA=3, OPB=5, MULSEQ_EARLY_EXIT_EN -> DONE after edge 5, RESULT=0x000F, OVF=0.
REQ-036 OPA=0x0100, OPB=0x0100 -> RESULT=0x0000, OVF=1; OPA=0xFFFF, OPB=1 -> RESULT=0xFFFF, OVF=0.
REQ-037 Second START pulsed while BUSY=1 -> ignored; first result unchanged and exactly one DONE.
REQ-038 RST_N low at edge 7 of a 0x1234*0x00FF op -> BUSY=0 and RESULT=0 at once, no DONE; a new 2*2 op -> RESULT=0x0004.
REQ-039 START in the DONE cycle with OPA=7, OPB=6 -> back-to-back accept; next RESULT=0x002A, OVF=0.
